// File: rtl/cpc_bus_slot_ctrl.sv
// Bus slot controller: divides the CPU clock-enable into fixed-length slots,
// holds Z80 accesses until the CPU phase and arbitrates slots with DMA requesters.
module cpc_bus_slot_ctrl #(
  parameter int unsigned SLOT_LEN    = 4,
  parameter int unsigned CPU_SLOT    = 0,
  parameter int unsigned N_DMA       = 3,
  parameter int unsigned MAX_DMA_RUN = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        no_wait,
  input  logic                        mreq_n,
  input  logic                        iorq_n,
  input  logic                        rfsh_n,
  input  logic [N_DMA-1:0]            dma_req,
  output logic                        wait_n,
  output logic [$clog2(SLOT_LEN)-1:0] phase,
  output logic                        cyc,
  output logic [N_DMA-1:0]            dma_gnt,
  output logic                        cpu_slot
);

  localparam int unsigned PH_W  = $clog2(SLOT_LEN);
  localparam int unsigned RUN_W = (MAX_DMA_RUN == 0) ? 1 : $clog2(MAX_DMA_RUN + 1);

  logic             acc_d;
  logic             wr;
  logic [RUN_W-1:0] run;

  logic             acc_c;
  logic             start_c;
  logic             slot_end_c;
  logic             run_max_c;
  logic             starve_c;
  logic [N_DMA-1:0] cand_c;

  logic [PH_W-1:0]  phase_nxt;
  logic             wr_nxt;
  logic [N_DMA-1:0] gnt_nxt;
  logic [RUN_W-1:0] run_nxt;

  // Refresh cycles drive MREQ_n low but are not CPU accesses.
  assign acc_c      = (mreq_n | ~rfsh_n) & iorq_n;
  assign start_c    = acc_d & ~acc_c;
  assign slot_end_c = (phase == PH_W'(SLOT_LEN - 1));
  assign run_max_c  = (run == RUN_W'(MAX_DMA_RUN));
  assign starve_c   = (MAX_DMA_RUN != 0) && run_max_c && !wr;

  assign cyc      = slot_end_c;
  assign cpu_slot = ~|dma_gnt;
  assign wait_n   = wr | no_wait;

  // Fixed priority: lowest-index request wins.
  always_comb begin
    cand_c = '0;
    for (int unsigned i = 0; i < N_DMA; i++) begin
      if (dma_req[i] && (cand_c == '0)) cand_c[i] = 1'b1;
    end
  end

  // Next-state for phase, wait hold and slot ownership.
  always_comb begin
    phase_nxt = slot_end_c ? '0 : phase + PH_W'(1);
    wr_nxt    = wr;
    gnt_nxt   = dma_gnt;
    run_nxt   = run;

    // Release beats start so an access opening on the release tick never waits.
    if ((phase == PH_W'(CPU_SLOT)) && cpu_slot) begin
      wr_nxt = 1'b1;
    end else if (start_c) begin
      wr_nxt = 1'b0;
    end

    if (slot_end_c) begin
      if (starve_c || (cand_c == '0)) begin
        gnt_nxt = '0;
        run_nxt = '0;
      end else begin
        gnt_nxt = cand_c;
        if (!run_max_c) run_nxt = run + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase   <= '0;
      acc_d   <= 1'b1;
      wr      <= 1'b1;
      dma_gnt <= '0;
      run     <= '0;
    end else if (ce) begin
      phase   <= phase_nxt;
      acc_d   <= acc_c;
      wr      <= wr_nxt;
      dma_gnt <= gnt_nxt;
      run     <= run_nxt;
    end
  end

endmodule

// File: doc/cpc_bus_slot_ctrl.md
Name: cpc_bus_slot_ctrl

Overview:
- Parametrised successor to the motherboard's fixed 1 MHz CPU wait-state glue.
- Divides the CPU clock-enable into bus slots of configurable length.
- Stretches Z80 memory/IO cycles to the CPU access phase, and arbitrates whole slots between the CPU and N_DMA requesters (e.g. sound DMA channels) with a CPU-starvation guard.
- Sits between the T80 bus strobes and the ASIC/PSG timing; emits the slot strobe used in place of the old cyc1MHz.

Parameters:
SLOT_LEN, 4, ce ticks per bus slot (2..16).
CPU_SLOT, 0, phase value at which a pending CPU wait is released (0..SLOT_LEN-1).
N_DMA, 3, number of DMA requesters (1..8).
MAX_DMA_RUN, 2, max consecutive DMA slots while the CPU is waiting; 0 = unlimited.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous, active-low reset.
ce  in  1  CPU clock-enable (ce_4p equivalent); all state advances only when ce=1.
no_wait  in  1  turbo: forces wait_n output high.
mreq_n  in  1  Z80 MREQ_n.
iorq_n  in  1  Z80 IORQ_n.
rfsh_n  in  1  Z80 RFSH_n.
dma_req  in  N_DMA  level requests, bit i = channel i.
wait_n  out  1  CPU wait/clock-hold, active low.
phase  out  $clog2(SLOT_LEN)  current phase within the slot.
cyc  out  1  high while phase==SLOT_LEN-1 (slot-end strobe, one ce period wide).
dma_gnt  out  N_DMA  one-hot grant for the current slot; all-zero = CPU slot.
cpu_slot  out  1  ~|dma_gnt.

Behaviour:
- Reset (reset_n=0 at a clk edge, regardless of ce):
  - phase=0, wait_n=1, dma_gnt=0, run counter=0, acc history=1.
  - Reset mid-grant or mid-wait aborts it on the next clk.
- Phase counter:
  - On ce: phase <= (phase==SLOT_LEN-1) ? 0 : phase+1.
  - cyc is combinational from the phase register.
- Access detect:
  - acc = (mreq_n | ~rfsh_n) & iorq_n; refresh cycles are not accesses.
  - acc_d is registered on ce.
  - start = ce & acc_d & ~acc (falling edge).
- Internal wait register wr:
  - On ce, if start, wr <= 0.
  - On ce, if phase==CPU_SLOT and cpu_slot==1, wr <= 1. Release has priority over start on the same ce, so an access beginning on the release tick incurs no wait.
  - Release is suppressed during DMA-granted slots; wr stays low until CPU_SLOT in the next CPU slot.
- Output: wait_n = wr | no_wait. Internal tracking continues while no_wait=1.
- Arbitration:
  - Evaluated on the ce with phase==SLOT_LEN-1; the new dma_gnt takes effect at phase 0 and is held for exactly SLOT_LEN ce ticks.
  - Candidate = lowest-index set bit of dma_req sampled at that tick (fixed priority).
  - Requests dropped mid-slot do not shorten the grant.
- Starvation guard:
  - run counts consecutive granted slots.
  - If MAX_DMA_RUN!=0, run==MAX_DMA_RUN and wr==0 (CPU waiting), the next slot is forced to CPU (dma_gnt=0) and run <= 0.
  - Any CPU slot resets run to 0.
  - When the CPU is not waiting, DMA may run unlimited; run saturates at MAX_DMA_RUN.
- Width rules:
  - phase width is $clog2(SLOT_LEN).
  - run width is $clog2(MAX_DMA_RUN+1), minimum 1.
  - No arithmetic overflow paths.
- Outputs change only at clk edges where ce=1 (or on reset); ce=0 freezes everything.

Test Plan:
1. SLOT_LEN=4, CPU_SLOT=0, no DMA; mreq_n falls so start occurs at phase=1 -> wait_n low for 3 ce ticks (phases 2,3,0→release at phase 0 tick), high from phase 1; cyc high only at phase 3.
2. Start coincident with phase==CPU_SLOT tick -> wait_n never drops. Refresh cycle (mreq_n=0, rfsh_n=0) -> no wait.
3. no_wait=1 with repeated accesses -> wait_n constantly 1. Drop no_wait while wr==0 -> wait_n goes low immediately, releases at next CPU_SLOT tick.
4. dma_req=3'b101 held, CPU idle -> dma_gnt=001 for 4 ce, then 001 repeatedly; drop bit0 before a slot end -> next slot gnt=100; dma_req=0 -> gnt=000, cpu_slot=1.
5. MAX_DMA_RUN=2, dma_req=3'b010 continuous, CPU access pending -> gnt 010,010, then 000 slot with wait_n released at CPU_SLOT, then 010 resumes.
6. reset_n=0 for one clk mid-grant with wr==0 -> next clk: dma_gnt=0, wait_n=1, phase=0; normal operation resumes from phase 0.
